// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM behind a request/acknowledge handshake.
// A request is sampled only in IDLE; reads go IDLE->READ->READ2->DONE, writes
// IDLE->WRITE->DONE, and out-of-range addresses go straight to DONE with err.
// Optional feature macro: MEM_PARITY_EN adds a stored even-parity bit per word,
// the inj_par input to corrupt it on write, and parity checking on read.
module ram_responder #(
    parameter int ADR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
`ifdef MEM_PARITY_EN
    input  logic        inj_par,
`endif
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic [7:0]  status
);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = 17;
`else
    localparam int WORD_W = 16;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        READ2 = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [ADR_W-1:0]   addr_q;
    logic [15:0]        wdata_q;
    logic [WORD_W-1:0]  memRd_q;
    logic [15:0]        rdata_q;
    logic               ack_q;
    logic               busy_q;
    logic               err_q;
    logic [7:0]         status_q;

    logic [WORD_W-1:0]  mem [0:(1<<ADR_W)-1];

    logic [WORD_W-1:0]  word_d;
    logic               parErr_d;
    logic               inRange_d;

    // An address is usable only if every bit above the array index is zero.
    assign inRange_d = ((addr >> ADR_W) == 16'd0);

`ifdef MEM_PARITY_EN
    logic               injPar_q;

    // Even parity over the data, optionally inverted to plant a fault; a read
    // word whose 17 bits do not XOR to zero carries a parity error.
    assign word_d   = {(^wdata_q) ^ injPar_q, wdata_q};
    assign parErr_d = ^memRd_q;
`else
    assign word_d   = wdata_q;
    assign parErr_d = 1'b0;
`endif

    assign rdata  = rdata_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign status = status_q;

    // Array port: commit on the edge leaving WRITE, capture the read word on the
    // edge leaving READ. Contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if (state_q == WRITE) begin
            mem[addr_q] <= word_d;
        end
        if (state_q == READ) begin
            memRd_q <= mem[addr_q];
        end
    end

    // Control FSM with registered Moore outputs; a request is latched only in
    // IDLE so anything presented while busy is simply ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
`ifdef MEM_PARITY_EN
            injPar_q <= 1'b0;
`endif
            rdata_q  <= 16'h0000;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            status_q <= 8'h01;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q   <= addr[ADR_W-1:0];
                        wdata_q  <= wdata;
`ifdef MEM_PARITY_EN
                        injPar_q <= inj_par;
`endif
                        busy_q   <= 1'b1;
                        if (!inRange_d) begin
                            state_q  <= DONE;
                            ack_q    <= 1'b1;
                            err_q    <= 1'b1;
                            status_q <= 8'h90;
                        end else if (we) begin
                            state_q  <= WRITE;
                            status_q <= 8'h08;
                        end else begin
                            state_q  <= READ;
                            status_q <= 8'h02;
                        end
                    end else begin
                        busy_q   <= 1'b0;
                        status_q <= 8'h01;
                    end
                end
                READ: begin
                    state_q  <= READ2;
                    busy_q   <= 1'b1;
                    status_q <= 8'h04;
                end
                READ2: begin
                    state_q  <= DONE;
                    rdata_q  <= memRd_q[15:0];
                    ack_q    <= 1'b1;
                    err_q    <= parErr_d;
                    busy_q   <= 1'b1;
                    status_q <= {parErr_d, 7'h10};
                end
                WRITE: begin
                    state_q  <= DONE;
                    ack_q    <= 1'b1;
                    busy_q   <= 1'b1;
                    status_q <= 8'h10;
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    status_q <= 8'h01;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    status_q <= 8'h01;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder (ADR_W=8).
// Expected values are hand-computed; a parity section is added when the
// MEM_PARITY_EN macro is defined.
module tb_ram_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        injPar;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;
    logic [7:0]  status;

    int checks;
    int errors;

    ram_responder #(
        .ADR_W(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
`ifdef MEM_PARITY_EN
        .inj_par(injPar),
`endif
        .rdata  (rdata),
        .ack    (ack),
        .busy   (busy),
        .err    (err),
        .status (status)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one sampling edge, returning #1 after it.
    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                                 input logic p);
        req    = 1'b1;
        we     = w;
        addr   = a;
        wdata  = d;
        injPar = p;
        @(posedge clk);
        #1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = 16'hFFFF;
        wdata  = 16'h0000;
        injPar = 1'b0;
    endtask

    // Counts edges from the sampling edge (inclusive) until ack is seen, bounded.
    task automatic waitAck(output int lat);
        lat = 1;
        while (ack !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One complete access: latency, outputs at ack, then the return to IDLE.
    task automatic doAccess(input string tag, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic p, input int expLat,
                            input logic [15:0] expRdata, input logic expErr);
        int lat;
        applyStimulus(w, a, d, p);
        waitAck(lat);
        checkOutput({tag, "_latency"}, lat[15:0], expLat[15:0]);
        checkOutput({tag, "_rdata"}, rdata, expRdata);
        checkOutput({tag, "_err"}, {15'd0, err}, {15'd0, expErr});
        checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd1);
        checkOutput({tag, "_status"}, {8'd0, status}, {8'd0, expErr, 7'h10});
        @(posedge clk);
        #1;
        checkOutput({tag, "_ackAfter"}, {15'd0, ack}, 16'd0);
        checkOutput({tag, "_idleStatus"}, {8'd0, status}, 16'h0001);
    endtask

    initial begin
        int         ackCount;
        logic [15:0] expData;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = 16'h0000;
        wdata  = 16'h0000;
        injPar = 1'b0;

        #1;
        checkOutput("reset_ack", {15'd0, ack}, 16'd0);
        checkOutput("reset_busy", {15'd0, busy}, 16'd0);
        checkOutput("reset_err", {15'd0, err}, 16'd0);
        checkOutput("reset_rdata", rdata, 16'h0000);
        checkOutput("reset_status", {8'd0, status}, 16'h0001);
        #11;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic write/read");
        doAccess("w5", 1'b1, 16'h0005, 16'hBEEF, 1'b0, 2, 16'h0000, 1'b0);
        doAccess("r5", 1'b0, 16'h0005, 16'h0000, 1'b0, 3, 16'hBEEF, 1'b0);
        doAccess("w7", 1'b1, 16'h0007, 16'hA5A5, 1'b0, 2, 16'hBEEF, 1'b0);
        doAccess("r7", 1'b0, 16'h0007, 16'h0000, 1'b0, 3, 16'hA5A5, 1'b0);

        $display("[TB] out-of-range accesses");
        doAccess("oorRead", 1'b0, 16'h0100, 16'h0000, 1'b0, 1, 16'hA5A5, 1'b1);
        doAccess("oorWrite", 1'b1, 16'h0105, 16'hDEAD, 1'b0, 1, 16'hA5A5, 1'b1);
        doAccess("r5Unchanged", 1'b0, 16'h0005, 16'h0000, 1'b0, 3, 16'hBEEF, 1'b0);

        $display("[TB] reset during WRITE");
        applyStimulus(1'b1, 16'h0007, 16'h1234, 1'b0);
        checkOutput("abort_inWrite", {8'd0, status}, 16'h0008);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_status", {8'd0, status}, 16'h0001);
        checkOutput("abort_busy", {15'd0, busy}, 16'd0);
        checkOutput("abort_rdata", rdata, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("abort_heldStatus", {8'd0, status}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) ackCount++;
        end
        checkOutput("abort_noAck", ackCount[15:0], 16'd0);
        doAccess("r7AfterAbort", 1'b0, 16'h0007, 16'h0000, 1'b0, 3, 16'hA5A5, 1'b0);

        $display("[TB] req held high with changing addresses");
        ackCount = 0;
        expData  = 16'h0000;
        for (int k = 1; k <= 16; k++) begin
            req  = 1'b1;
            we   = 1'b0;
            addr = (k % 3 == 0) ? 16'h0007 : 16'h0005;
            if (k % 4 == 1) expData = (k % 3 == 0) ? 16'hA5A5 : 16'hBEEF;
            @(posedge clk);
            #1;
            checkOutput($sformatf("held_busy_%0d", k), {15'd0, busy}, {15'd0, (k % 4 != 0)});
            checkOutput($sformatf("held_ack_%0d", k), {15'd0, ack}, {15'd0, (k % 4 == 3)});
            if (ack === 1'b1) begin
                ackCount++;
                checkOutput($sformatf("held_rdata_%0d", k), rdata, expData);
            end
        end
        req  = 1'b0;
        addr = 16'hFFFF;
        checkOutput("held_ackCount", ackCount[15:0], 16'd4);

`ifdef MEM_PARITY_EN
        $display("[TB] parity injection");
        doAccess("parWriteBad", 1'b1, 16'h000A, 16'h00FF, 1'b1, 2, 16'hBEEF, 1'b0);
        doAccess("parReadBad", 1'b0, 16'h000A, 16'h0000, 1'b0, 3, 16'h00FF, 1'b1);
        doAccess("parWriteGood", 1'b1, 16'h000A, 16'h00FF, 1'b0, 2, 16'h00FF, 1'b0);
        doAccess("parReadGood", 1'b0, 16'h000A, 16'h0000, 1'b0, 3, 16'h00FF, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter: ADR_W, default 8, log2 of memory depth in 16-bit words (256 words by default).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  1  access request from the control unit/datapath; sampled only in IDLE.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 addr  input  16  word address; sampled with req.
REQ-007 wdata  input  16  write data; sampled with req.
REQ-008 rdata  output  16  read data; valid while ack=1, held until the next read completes.
REQ-009 ack  output  1  one-cycle completion strobe for every accepted request.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  error flag; valid only while ack=1.
REQ-012 status  output  8  LED pattern showing the current state.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, READ, READ2, WRITE and DONE; all outputs are decoded from state and registers.
REQ-014 In IDLE with req=1 and addr[15:ADR_W]≠0, the block SHALL go to DONE with no array access and set err=1 for that ack.
REQ-015 In IDLE with req=1, in-range addr and we=0, the block SHALL go IDLE→READ→READ2→DONE: array read registered in READ, rdata registered in READ2, ack=1 in DONE.
REQ-016 In IDLE with req=1, in-range addr and we=1, the block SHALL go IDLE→WRITE→DONE; the array is written on the edge leaving WRITE.
REQ-017 Read latency SHALL be 3 cycles from the sampling edge to ack high; write latency SHALL be 2 cycles.
REQ-018 DONE SHALL always return to IDLE, so back-to-back requests complete at most once every 4 (read) or 3 (write) cycles.
REQ-019 req, we, addr and wdata SHALL be latched at the sampling edge; changes while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 A write to a location SHALL be visible to a read accepted on the cycle after the write ack.
REQ-021 status SHALL be IDLE=8'h01, READ=8'h02, READ2=8'h04, WRITE=8'h08, DONE=8'h10; bit 7 SHALL be ORed with err in DONE.
REQ-022 Memory contents SHALL NOT be initialised; reading a never-written word returns an undefined value.

Reset
REQ-023 reset SHALL force state=IDLE, ack=0, busy=0, err=0, rdata=16'h0000 and status=8'h01 immediately and asynchronously.
REQ-024 If reset asserts while in WRITE before the commit edge, the write SHALL NOT be committed; any in-flight read SHALL be dropped with no ack.

Configuration
REQ-025 With MEM_PARITY_EN defined, each word SHALL store a 17th even-parity bit computed on write, plus an input inj_par (1 bit) that inverts the stored parity bit of a write when high at the sampling edge.
REQ-026 With MEM_PARITY_EN defined, a read whose stored parity mismatches SHALL return the data with err=1 at ack.
REQ-027 Without MEM_PARITY_EN, the array SHALL be 16 bits wide, inj_par SHALL be absent, and err SHALL indicate range errors only.

Verification
REQ-028 Write addr=16'h0005, wdata=16'hBEEF, then read 16'h0005 -> write ack 2 cycles after its request; read ack 3 cycles after its request with rdata=16'hBEEF and err=0.
REQ-029 Read addr=16'h0100 (ADR_W=8) -> ack with err=1, status=8'h90, and the array is unchanged.
REQ-030 Hold req=1 continuously with alternating addresses -> exactly one ack per accepted request; busy=1 between acceptance and DONE, with no extra acks.
REQ-031 Assert reset in WRITE (addr=16'h0007, wdata=16'h1234), then read 16'h0007 -> the old value is returned, ack never fires for the aborted write, and status=8'h01 after reset.
REQ-032 MEM_PARITY_EN: write 16'h00FF with inj_par=1, then read it -> rdata=16'h00FF with err=1; the same test with inj_par=0 gives err=0.
